softmax_row_sched: RTL and testbench
====================================

Name: softmax_row_sched

Overview:
- Row scheduler for the 8-bit three-pass Softmax engine.
- For each attention-score row it reads `ch` elements from the score buffer three times (max pass, exp-sum pass, output pass) and drives the engine's valid/data/scale/channel inputs.
- Holds the engine's configuration stable for the whole row and inserts the guard gap the engine's log pipeline needs between pass 2 and pass 3.
- Writes the `ch` normalised outputs back to the destination buffer. Sits between the attention matrix buffer arbiter and the Softmax datapath.

Parameters:
- ADDR_W, 16, buffer word-address width.
- LOG2_CH, 10, width of the channel-count field driven to the engine.
- MAX_CH, 341, largest legal `ch`; 3*ch-1 must fit in the engine's 10-bit beat counter.
- GAP, 4, idle cycles inserted between the last pass-2 beat and the first pass-3 beat.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle job start; sampled only in IDLE
- abort  in  1  synchronous job kill
- cfg_ch  in  LOG2_CH  elements per row
- cfg_rows  in  16  row count
- cfg_scale_in  in  4  input scale (1..10)
- cfg_scale_out  in  4  output scale (7..12)
- cfg_src_base  in  ADDR_W  first source word
- cfg_dst_base  in  ADDR_W  first destination word
- busy  out  1  job in progress
- done  out  1  one-cycle completion pulse
- err  out  1  sticky illegal-config flag; cleared by the next start
- rd_req  out  1  buffer read request
- rd_gnt  in  1  read accepted this cycle
- rd_addr  out  ADDR_W  read address
- rd_data  in  8  read data; valid exactly 1 cycle after rd_req&rd_gnt
- sm_rst_n  out  1  engine reset, active-low
- sm_ch_in  out  LOG2_CH  latched ch
- sm_scale_in  out  4  latched scale_in
- sm_scale_out  out  4  latched scale_out
- sm_data_in  out  8  engine data
- sm_valid_in  out  1  engine beat valid
- sm_data_out  in  8  engine result
- sm_valid_out  in  1  engine result valid
- wr_en  out  1  destination write
- wr_addr  out  ADDR_W  write address
- wr_data  out  8  write data

Behaviour:
- Reset values: all outputs 0 except sm_rst_n, which is 0 while rst=1 and for 1 cycle after rst falls. FSM in IDLE.
- Config latch: on start in IDLE, latch all cfg_* inputs.
  - If cfg_ch==0 or cfg_ch>MAX_CH, set err=1 and pulse done the next cycle with no traffic.
  - If cfg_rows==0, pulse done the next cycle with err=0.
  - start while busy is ignored.
- FSM: IDLE -> P1 -> P2 -> GAP -> P3 -> DRAIN -> (P1 of next row | FIN) -> IDLE.
  - busy=1 in every state except IDLE.
  - FIN lasts 1 cycle and drives done=1.
- Pass states P1, P2 and P3 are identical:
  - rd_req=1 with rd_addr = row_base + idx.
  - idx advances only on rd_req&rd_gnt. The pass ends on the grant with idx==ch-1; idx then clears.
  - rd_req drops in the cycle after the final grant.
  - rd_gnt low stalls the pass with no error; gaps in sm_valid_in are legal.
- Engine drive:
  - sm_valid_in is rd_req&rd_gnt registered 1 cycle; sm_data_in = rd_data in that same cycle.
  - Exactly 3*ch valid beats per row, in element order 0..ch-1 on each pass.
  - sm_ch_in, sm_scale_in and sm_scale_out are constant from P1 entry until FIN.
- GAP: count GAP cycles after the final P2 beat has been presented on sm_valid_in. No requests during GAP.
- DRAIN:
  - Each sm_valid_out produces wr_en=1 the same cycle, with wr_data = sm_data_out and wr_addr = dst_row_base + oidx; oidx then increments.
  - Leave DRAIN when oidx reaches ch; oidx clears.
  - Any sm_valid_out outside P3/DRAIN is ignored; this is a verification-checked violation.
- Row bookkeeping: row_base += ch and dst_row_base += ch per row, both modulo 2^ADDR_W (wrap permitted). Row counter runs 0..rows-1.
- Abort or rst mid-job:
  - rd_req, sm_valid_in and wr_en go 0 the next cycle.
  - sm_rst_n is held 0 for 2 cycles so the engine beat counter, running max and sum clear.
  - FSM returns to IDLE with no done pulse. abort in IDLE has no effect.
- start coincident with abort: abort wins and the job is not started.
- Throughput with rd_gnt held 1: 3*ch + GAP + engine latency (11) + small fixed overhead per row.

Test Plan:
- ch=4, rows=1, scores {0,0,0,0}, scale_in=10, scale_out=7, rd_gnt=1 -> 12 sm_valid_in beats in order 0..3,0..3,0..3; GAP=4 idle cycles after beat 8; 4 writes to dst_base..dst_base+3, each ~0x20 (0.25 at Q7); done pulses once; busy drops the same cycle done falls.
- Same job with rd_gnt toggling every other cycle -> identical wr_data and addresses, still exactly 12 engine beats, sm_scale_* stable throughout.
- ch=3, rows=3, src_base=0xFFFE -> rows read at 0xFFFE, 0x0001, 0x0004 (wrap); 9 writes; done after the third DRAIN.
- cfg_ch=0, then cfg_ch=342 -> err=1, done next cycle, no rd_req or wr_en. cfg_rows=0 -> done with err=0.
- abort during P2 of row 0 -> traffic stops next cycle, sm_rst_n low 2 cycles, no done. A new start with ch=4 then produces results bit-identical to the first test.
- start asserted while busy -> ignored; the latched config is unchanged and the original job completes normally.

Source files
------------

// File: rtl/softmax_row_sched.sv
// Row scheduler for the three-pass Softmax engine: streams each score row
// three times into the engine, holds its configuration per job, inserts the
// log-pipeline guard gap before the output pass and writes results back.
module softmax_row_sched #(
  parameter int ADDR_W  = 16,
  parameter int LOG2_CH = 10,
  parameter int MAX_CH  = 341,
  parameter int GAP     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [LOG2_CH-1:0] cfg_ch,
  input  logic [15:0]        cfg_rows,
  input  logic [3:0]         cfg_scale_in,
  input  logic [3:0]         cfg_scale_out,
  input  logic [ADDR_W-1:0]  cfg_src_base,
  input  logic [ADDR_W-1:0]  cfg_dst_base,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               rd_req,
  input  logic               rd_gnt,
  output logic [ADDR_W-1:0]  rd_addr,
  input  logic [7:0]         rd_data,
  output logic               sm_rst_n,
  output logic [LOG2_CH-1:0] sm_ch_in,
  output logic [3:0]         sm_scale_in,
  output logic [3:0]         sm_scale_out,
  output logic [7:0]         sm_data_in,
  output logic               sm_valid_in,
  input  logic [7:0]         sm_data_out,
  input  logic               sm_valid_out,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [7:0]         wr_data
);

  typedef enum logic [2:0] {
    S_IDLE, S_P1, S_P2, S_GAP, S_P3, S_DRAIN, S_FIN
  } state_t;

  localparam logic [LOG2_CH-1:0] MAX_CH_W = LOG2_CH'(MAX_CH);
  localparam logic [LOG2_CH-1:0] ONE_CH   = LOG2_CH'(1);
  localparam logic [7:0]         GAP_LAST = 8'(GAP - 1);

  state_t              state_q, state_d;
  logic [LOG2_CH-1:0]  ch_q, ch_d;
  logic [15:0]         rows_q, rows_d;
  logic [3:0]          sin_q, sin_d, sout_q, sout_d;
  logic [ADDR_W-1:0]   row_base_q, row_base_d, dst_base_q, dst_base_d;
  logic [15:0]         row_cnt_q, row_cnt_d;
  logic [LOG2_CH-1:0]  idx_q, idx_d, oidx_q, oidx_d;
  logic [7:0]          gap_q, gap_d;
  logic                bubble_q, bubble_d;
  logic                err_q, err_d;
  logic                vin_q;
  logic                smrst_q, hold_q;

  logic start_ok_s, cfg_bad_s, in_pass_s, rd_req_s, gnt_s, last_s, wr_en_s;

  assign start_ok_s = (state_q == S_IDLE) && start && !abort;
  assign cfg_bad_s  = (cfg_ch == '0) || (cfg_ch > MAX_CH_W);
  assign in_pass_s  = (state_q == S_P1) || (state_q == S_P2) || (state_q == S_P3);
  // One idle request cycle follows the final grant of every pass.
  assign rd_req_s   = in_pass_s && !bubble_q;
  assign gnt_s      = rd_req_s && rd_gnt;
  assign last_s     = gnt_s && (idx_q == ch_q - ONE_CH);
  // Engine results are only meaningful while the output pass is in flight.
  assign wr_en_s    = sm_valid_out && ((state_q == S_P3) || (state_q == S_DRAIN));

  // Next-state, configuration latch and row/element bookkeeping.
  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    rows_d     = rows_q;
    sin_d      = sin_q;
    sout_d     = sout_q;
    row_base_d = row_base_q;
    dst_base_d = dst_base_q;
    row_cnt_d  = row_cnt_q;
    idx_d      = idx_q;
    oidx_d     = oidx_q;
    gap_d      = gap_q;
    bubble_d   = 1'b0;
    err_d      = err_q;
    case (state_q)
      S_IDLE: begin
        if (start_ok_s) begin
          ch_d       = cfg_ch;
          rows_d     = cfg_rows;
          sin_d      = cfg_scale_in;
          sout_d     = cfg_scale_out;
          row_base_d = cfg_src_base;
          dst_base_d = cfg_dst_base;
          row_cnt_d  = 16'd0;
          idx_d      = '0;
          oidx_d     = '0;
          err_d      = cfg_bad_s;
          if (cfg_bad_s || (cfg_rows == 16'd0)) begin
            state_d = S_FIN;
          end else begin
            state_d = S_P1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_P1, S_P2, S_P3: begin
        if ((state_q == S_P3) && wr_en_s) begin
          oidx_d = oidx_q + ONE_CH;
        end else begin
          oidx_d = oidx_q;
        end
        if (last_s) begin
          idx_d = '0;
          if (state_q == S_P1) begin
            state_d  = S_P2;
            bubble_d = 1'b1;
          end else if (state_q == S_P2) begin
            state_d = S_GAP;
            gap_d   = 8'd0;
          end else begin
            state_d = S_DRAIN;
          end
        end else if (gnt_s) begin
          idx_d = idx_q + ONE_CH;
        end else begin
          idx_d = idx_q;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = S_P3;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      S_DRAIN: begin
        if (wr_en_s && (oidx_q == ch_q - ONE_CH)) begin
          oidx_d = '0;
          if (row_cnt_q == rows_q - 16'd1) begin
            state_d = S_FIN;
          end else begin
            state_d    = S_P1;
            row_cnt_d  = row_cnt_q + 16'd1;
            row_base_d = row_base_q + ADDR_W'(ch_q);
            dst_base_d = dst_base_q + ADDR_W'(ch_q);
          end
        end else if (wr_en_s) begin
          oidx_d = oidx_q + ONE_CH;
        end else begin
          oidx_d = oidx_q;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (abort && (state_q != S_IDLE)) begin
      state_d  = S_IDLE;
      idx_d    = '0;
      oidx_d   = '0;
      gap_d    = 8'd0;
      bubble_d = 1'b0;
    end else begin
      bubble_d = bubble_d;
    end
  end

  // Scheduler state and latched job configuration.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ch_q       <= '0;
      rows_q     <= 16'd0;
      sin_q      <= 4'd0;
      sout_q     <= 4'd0;
      row_base_q <= '0;
      dst_base_q <= '0;
      row_cnt_q  <= 16'd0;
      idx_q      <= '0;
      oidx_q     <= '0;
      gap_q      <= 8'd0;
      bubble_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      rows_q     <= rows_d;
      sin_q      <= sin_d;
      sout_q     <= sout_d;
      row_base_q <= row_base_d;
      dst_base_q <= dst_base_d;
      row_cnt_q  <= row_cnt_d;
      idx_q      <= idx_d;
      oidx_q     <= oidx_d;
      gap_q      <= gap_d;
      bubble_q   <= bubble_d;
      err_q      <= err_d;
    end
  end

  // Engine beat strobe and engine reset stretcher (two cycles after abort).
  always_ff @(posedge clk) begin
    if (rst) begin
      vin_q   <= 1'b0;
      smrst_q <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      vin_q <= gnt_s && !abort;
      if (abort && (state_q != S_IDLE)) begin
        smrst_q <= 1'b0;
        hold_q  <= 1'b1;
      end else if (hold_q) begin
        smrst_q <= 1'b0;
        hold_q  <= 1'b0;
      end else begin
        smrst_q <= 1'b1;
        hold_q  <= 1'b0;
      end
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_FIN);
  assign err          = err_q;
  assign rd_req       = rd_req_s;
  assign rd_addr      = rd_req_s ? (row_base_q + ADDR_W'(idx_q)) : '0;
  assign sm_rst_n     = smrst_q;
  assign sm_ch_in     = ch_q;
  assign sm_scale_in  = sin_q;
  assign sm_scale_out = sout_q;
  assign sm_valid_in  = vin_q;
  assign sm_data_in   = vin_q ? rd_data : 8'h00;
  assign wr_en        = wr_en_s;
  assign wr_addr      = wr_en_s ? (dst_base_q + ADDR_W'(oidx_q)) : '0;
  assign wr_data      = wr_en_s ? sm_data_out : 8'h00;

endmodule

// File: tb/tb_softmax_row_sched.sv
// Directed bench for softmax_row_sched with a score-buffer model and a
// simple 11-cycle engine stand-in (output = pass-3 input + 0x20).
module tb_softmax_row_sched;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [9:0]  cfg_ch;
  logic [15:0] cfg_rows;
  logic [3:0]  cfg_scale_in, cfg_scale_out;
  logic [15:0] cfg_src_base, cfg_dst_base;
  logic        busy, done, err, rd_req, sm_rst_n, sm_valid_in, wr_en;
  logic        rd_gnt = 1'b0;
  logic [15:0] rd_addr, wr_addr;
  logic [7:0]  rd_data = 8'h00;
  logic [9:0]  sm_ch_in;
  logic [3:0]  sm_scale_in, sm_scale_out;
  logic [7:0]  sm_data_in, sm_data_out, wr_data;
  logic        sm_valid_out;

  int n_chk = 0;
  int n_fail = 0;

  softmax_row_sched dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_ch(cfg_ch), .cfg_rows(cfg_rows), .cfg_scale_in(cfg_scale_in),
    .cfg_scale_out(cfg_scale_out), .cfg_src_base(cfg_src_base),
    .cfg_dst_base(cfg_dst_base), .busy(busy), .done(done), .err(err),
    .rd_req(rd_req), .rd_gnt(rd_gnt), .rd_addr(rd_addr), .rd_data(rd_data),
    .sm_rst_n(sm_rst_n), .sm_ch_in(sm_ch_in), .sm_scale_in(sm_scale_in),
    .sm_scale_out(sm_scale_out), .sm_data_in(sm_data_in),
    .sm_valid_in(sm_valid_in), .sm_data_out(sm_data_out),
    .sm_valid_out(sm_valid_out), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  // Score buffer and grant pattern
  logic [7:0] mem [0:65535];
  bit gnt_tog = 1'b0;
  always @(posedge clk) begin
    rd_data <= (rd_req && rd_gnt) ? mem[rd_addr] : 8'hEE;
    rd_gnt  <= gnt_tog ? ~rd_gnt : 1'b1;
  end

  // Engine stand-in: counts beats modulo 3*ch, echoes pass-3 beats + 0x20
  logic [10:0] pv = '0;
  logic [7:0]  pd [0:10];
  int          eb = 0;
  always @(posedge clk) begin
    if (!sm_rst_n) begin
      pv <= '0;
      eb <= 0;
    end else begin
      pv    <= {pv[9:0], sm_valid_in && (eb >= 2 * int'(sm_ch_in))};
      pd[0] <= sm_data_in + 8'h20;
      for (int k = 1; k < 11; k++) pd[k] <= pd[k-1];
      if (sm_valid_in) eb <= (eb == 3 * int'(sm_ch_in) - 1) ? 0 : eb + 1;
    end
  end
  assign sm_valid_out = pv[10];
  assign sm_data_out  = pv[10] ? pd[10] : 8'h00;

  // Monitors, sampled on the falling edge
  int         cyc = 0;
  logic [7:0] beat_q[$];
  int         beat_cyc[$];
  logic [15:0] addr_q[$];
  logic [15:0] wa_q[$];
  logic [7:0]  wd_q[$];
  int          done_n = 0, req_n = 0, cfg_bad_n = 0;
  bit          chk_cfg = 1'b0;
  logic [9:0]  exp_ch;
  logic [3:0]  exp_si, exp_so;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (sm_valid_in) begin beat_q.push_back(sm_data_in); beat_cyc.push_back(cyc); end
    if (rd_req && rd_gnt) addr_q.push_back(rd_addr);
    if (wr_en) begin wa_q.push_back(wr_addr); wd_q.push_back(wr_data); end
    if (done) done_n <= done_n + 1;
    if (rd_req) req_n <= req_n + 1;
    if (chk_cfg && busy && ((sm_ch_in != exp_ch) || (sm_scale_in != exp_si) ||
        (sm_scale_out != exp_so))) cfg_bad_n <= cfg_bad_n + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    beat_q.delete(); beat_cyc.delete(); addr_q.delete();
    wa_q.delete(); wd_q.delete();
    done_n = 0; req_n = 0; cfg_bad_n = 0;
  endtask

  task automatic launch(input logic [9:0] ch, input logic [15:0] rows,
                        input logic [15:0] src, input logic [15:0] dst);
    cfg_ch = ch; cfg_rows = rows; cfg_src_base = src; cfg_dst_base = dst;
    cfg_scale_in = 4'd10; cfg_scale_out = 4'd7;
    exp_ch = ch; exp_si = 4'd10; exp_so = 4'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    @(negedge clk);
    chk({tag, "_busy_drop"}, 32'(busy), 32'd0);
    chk({tag, "_done_once_cyc"}, 32'(done), 32'd0);
    repeat (3) tick();
  endtask

  // Basic ch=4 single-row job with zero scores; also reused after abort
  task automatic run_basic(input string tag, input bit tog);
    gnt_tog = tog;
    tick();
    clear_mon();
    chk_cfg = 1'b1;
    launch(10'd4, 16'd1, 16'h0100, 16'h1000);
    wait_done(tag);
    chk_cfg = 1'b0;
    chk({tag, "_done_n"}, 32'(done_n), 32'd1);
    chk({tag, "_beats"}, 32'(beat_q.size()), 32'd12);
    chk({tag, "_reads"}, 32'(addr_q.size()), 32'd12);
    for (int k = 0; k < addr_q.size(); k++)
      chk({tag, "_rd_addr"}, 32'(addr_q[k]), 32'h100 + 32'(k % 4));
    if (!tog && beat_cyc.size() >= 9)
      chk({tag, "_gap"}, 32'(beat_cyc[8] - beat_cyc[7] - 1), 32'd4);
    chk({tag, "_writes"}, 32'(wa_q.size()), 32'd4);
    for (int k = 0; k < wa_q.size(); k++) begin
      chk({tag, "_wr_addr"}, 32'(wa_q[k]), 32'h1000 + 32'(k));
      chk({tag, "_wr_data"}, 32'(wd_q[k]), 32'h20);
    end
    chk({tag, "_cfg_stable"}, 32'(cfg_bad_n), 32'd0);
  endtask

  // Illegal or empty configuration: done next cycle, no traffic
  task automatic run_err(input string tag, input logic [9:0] ch,
                         input logic [15:0] rows, input bit exp_err);
    tick();
    clear_mon();
    launch(ch, rows, 16'h0100, 16'h1000);
    @(negedge clk);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
    tick();
    @(negedge clk);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_err_sticky"}, 32'(err), 32'(exp_err));
    repeat (20) tick();
    chk({tag, "_no_req"}, 32'(req_n), 32'd0);
    chk({tag, "_no_wr"}, 32'(wa_q.size()), 32'd0);
    chk({tag, "_done_n"}, 32'(done_n), 32'd1);
  endtask

  initial begin
    logic [15:0] a;
    int k;
    bit hit;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    cfg_ch = '0; cfg_rows = '0; cfg_scale_in = '0; cfg_scale_out = '0;
    cfg_src_base = '0; cfg_dst_base = '0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'(i) ^ 8'h3C;
    for (int i = 16'h100; i < 16'h104; i++) mem[i] = 8'h00;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rd_req", 32'(rd_req), 32'd0);
    chk("rst_vin", 32'(sm_valid_in), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_sm_rst_n", 32'(sm_rst_n), 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_sm_rst_n_hold", 32'(sm_rst_n), 32'd0);
    tick();
    @(negedge clk);
    chk("rst_sm_rst_n_rel", 32'(sm_rst_n), 32'd1);

    // Single row, continuous grant, then alternating grant
    run_basic("t1", 1'b0);
    run_basic("t2", 1'b1);

    // Three rows of three elements across the address wrap
    gnt_tog = 1'b0;
    tick();
    clear_mon();
    launch(10'd3, 16'd3, 16'hFFFE, 16'h2000);
    wait_done("t3");
    chk("t3_done_n", 32'(done_n), 32'd1);
    chk("t3_reads", 32'(addr_q.size()), 32'd27);
    chk("t3_beats", 32'(beat_q.size()), 32'd27);
    if (addr_q.size() == 27 && beat_q.size() == 27) begin
      for (int r = 0; r < 3; r++)
        for (int p = 0; p < 3; p++)
          for (int e = 0; e < 3; e++) begin
            k = r * 9 + p * 3 + e;
            a = 16'hFFFE + 16'(3 * r + e);
            chk("t3_rd_addr", 32'(addr_q[k]), 32'(a));
            chk("t3_beat_data", 32'(beat_q[k]), 32'(a[7:0] ^ 8'h3C));
          end
    end
    chk("t3_writes", 32'(wa_q.size()), 32'd9);
    if (wa_q.size() == 9) begin
      for (int j = 0; j < 9; j++) begin
        a = 16'hFFFE + 16'(j);
        chk("t3_wr_addr", 32'(wa_q[j]), 32'h2000 + 32'(j));
        chk("t3_wr_data", 32'(wd_q[j]), 32'((a[7:0] ^ 8'h3C) + 8'h20));
      end
    end

    // Illegal / empty configurations
    run_err("t4_ch0", 10'd0, 16'd1, 1'b1);
    run_err("t4_ch342", 10'd342, 16'd1, 1'b1);
    run_err("t4_rows0", 10'd4, 16'd0, 1'b0);

    // Abort during pass 2 of row 0
    tick();
    clear_mon();
    launch(10'd4, 16'd1, 16'h0100, 16'h1000);
    hit = 1'b0;
    for (int i = 0; i < 500 && !hit; i++) begin
      tick();
      if (beat_q.size() >= 5) hit = 1'b1;
    end
    chk("t5_reach_p2", 32'(hit), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    @(negedge clk);
    chk("t5_rd_req", 32'(rd_req), 32'd0);
    chk("t5_vin", 32'(sm_valid_in), 32'd0);
    chk("t5_wr_en", 32'(wr_en), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_sm_rst_n_a", 32'(sm_rst_n), 32'd0);
    tick();
    @(negedge clk);
    chk("t5_sm_rst_n_b", 32'(sm_rst_n), 32'd0);
    tick();
    @(negedge clk);
    chk("t5_sm_rst_n_rel", 32'(sm_rst_n), 32'd1);
    repeat (30) tick();
    chk("t5_no_done", 32'(done_n), 32'd0);
    chk("t5_no_wr", 32'(wa_q.size()), 32'd0);
    run_basic("t5_rerun", 1'b0);

    // Start while busy is ignored
    tick();
    clear_mon();
    chk_cfg = 1'b1;
    launch(10'd4, 16'd1, 16'h0100, 16'h3000);
    repeat (3) tick();
    cfg_ch = 10'd3; cfg_scale_in = 4'd5; cfg_scale_out = 4'd12; cfg_dst_base = 16'h4000;
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    chk("t6_ch_kept", 32'(sm_ch_in), 32'd4);
    chk("t6_sin_kept", 32'(sm_scale_in), 32'd10);
    chk("t6_sout_kept", 32'(sm_scale_out), 32'd7);
    wait_done("t6");
    chk_cfg = 1'b0;
    chk("t6_done_n", 32'(done_n), 32'd1);
    chk("t6_writes", 32'(wa_q.size()), 32'd4);
    for (int j = 0; j < wa_q.size(); j++) begin
      chk("t6_wr_addr", 32'(wa_q[j]), 32'h3000 + 32'(j));
      chk("t6_wr_data", 32'(wd_q[j]), 32'h20);
    end
    chk("t6_cfg_stable", 32'(cfg_bad_n), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Absolute time bound
  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
